// File: rtl/pipe_ctrl.sv
// Pipeline control: merges an EX redirect with layered hold requests into per-stage
// hold/flush vectors, drives the redirect handshake to pc_reg, a hold watchdog and a stall counter.
module pipe_ctrl #(
  parameter int unsigned STAGES   = 5,
  parameter int unsigned EX_STAGE = 2,
  parameter int unsigned NREQ     = 3,
  parameter int unsigned SW       = 3,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned WDOG_W   = 8,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 jump_flag_i,
  input  logic [ADDR_W-1:0]    jump_addr_i,
  input  logic [NREQ-1:0]      hold_req_i,
  input  logic [NREQ*SW-1:0]   hold_depth_i,
  input  logic                 cnt_clr_i,
  output logic                 jump_flag_o,
  output logic [ADDR_W-1:0]    jump_addr_o,
  output logic [STAGES-1:0]    hold_o,
  output logic [STAGES-1:0]    flush_o,
  output logic                 wdog_o,
  output logic [CNT_W-1:0]     stall_cnt_o
);

  localparam logic [STAGES-1:0] FLUSH_MASK = STAGES'((2 ** (EX_STAGE + 1)) - 2);
  localparam logic [WDOG_W-1:0] WDOG_MAX   = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

  typedef enum logic {ST_IDLE, ST_REDIRECT} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   jaddr_q, jaddr_d;
  logic [WDOG_W-1:0]   wcnt_q, wcnt_d;
  logic                wdog_q, wdog_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [STAGES-1:0]   hold_raw;
  logic                redirect_c;
  int unsigned         depth_max;
  int unsigned         field;

  // Deepest clamped freeze depth among active requesters sets the raw hold prefix
  always_comb begin
    depth_max = 0;
    field     = 0;
    for (int unsigned r = 0; r < NREQ; r++) begin
      if (hold_req_i[r]) begin
        field = 32'(hold_depth_i[r*SW +: SW]);
        if (field > STAGES) field = STAGES;
        if (field > depth_max) depth_max = field;
      end
    end
    for (int unsigned k = 0; k < STAGES; k++) begin
      hold_raw[k] = (k < depth_max);
    end
  end

  // Redirect FSM: stays in REDIRECT until pc_reg is not held
  always_comb begin
    state_d    = state_q;
    jaddr_d    = jaddr_q;
    redirect_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (jump_flag_i) begin
          state_d    = ST_REDIRECT;
          jaddr_d    = jump_addr_i;
          redirect_c = 1'b1;
        end
      end
      ST_REDIRECT: begin
        redirect_c = 1'b1;
        if (!hold_raw[0]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wcnt_d = '0;
    wdog_d = 1'b0;
    if (hold_req_i != '0) begin
      wcnt_d = (wcnt_q == WDOG_MAX) ? WDOG_MAX : wcnt_q + WDOG_W'(1);
      wdog_d = wdog_q | (wcnt_d == WDOG_MAX);
    end
    cnt_d = cnt_q;
    if (cnt_clr_i) cnt_d = '0;
    else if (hold_raw[0] && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      jaddr_q <= '0;
      wcnt_q  <= '0;
      wdog_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      jaddr_q <= jaddr_d;
      wcnt_q  <= wcnt_d;
      wdog_q  <= wdog_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs forced low while reset is asserted; flush overrides hold per stage
  always_comb begin
    flush_o     = (rst_n && redirect_c) ? FLUSH_MASK : '0;
    hold_o      = rst_n ? (hold_raw & ~flush_o) : '0;
    jump_flag_o = rst_n && (state_q == ST_REDIRECT);
    jump_addr_o = rst_n ? jaddr_q : '0;
    wdog_o      = rst_n && wdog_q;
    stall_cnt_o = rst_n ? cnt_q : '0;
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed scenarios then random traffic, checked
// against a cycle-level behavioural model (WDOG_W=4, CNT_W=4).
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        jump_flag_i = 1'b0;
  logic [31:0] jump_addr_i = '0;
  logic [2:0]  hold_req_i = '0;
  logic [8:0]  hold_depth_i = '0;
  logic        cnt_clr_i = 1'b0;
  logic        jump_flag_o;
  logic [31:0] jump_addr_o;
  logic [4:0]  hold_o;
  logic [4:0]  flush_o;
  logic        wdog_o;
  logic [3:0]  stall_cnt_o;

  int checks = 0;
  int errors = 0;

  pipe_ctrl #(.STAGES(5), .EX_STAGE(2), .NREQ(3), .SW(3), .ADDR_W(32),
              .WDOG_W(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .hold_req_i(hold_req_i), .hold_depth_i(hold_depth_i), .cnt_clr_i(cnt_clr_i),
    .jump_flag_o(jump_flag_o), .jump_addr_o(jump_addr_o), .hold_o(hold_o),
    .flush_o(flush_o), .wdog_o(wdog_o), .stall_cnt_o(stall_cnt_o));

  always #5 clk = ~clk;

  typedef struct packed {
    logic        jf;
    logic [31:0] addr;
    logic [4:0]  hold;
    logic [4:0]  flush;
    logic        wdog;
    logic [3:0]  cnt;
  } exp_t;

  exp_t sb[$];

  // Model state
  bit          m_redir = 0;
  logic [31:0] m_addr = '0;
  int          m_run = 0;
  int          m_cnt = 0;

  function automatic int depth_of(input logic [2:0] rq, input logic [8:0] dp);
    int d = 0;
    for (int r = 0; r < 3; r++) begin
      int f = int'(dp[r*3 +: 3]);
      if (f > 5) f = 5;
      if (rq[r] && f > d) d = f;
    end
    return d;
  endfunction

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Advance model state across a clock edge using the inputs that were applied
  task automatic model_edge();
    int d;
    if (!rst_n) begin
      m_redir = 0; m_addr = '0; m_run = 0; m_cnt = 0;
    end else begin
      d = depth_of(hold_req_i, hold_depth_i);
      if (cnt_clr_i) m_cnt = 0;
      else if (d > 0 && m_cnt < 15) m_cnt++;
      if (hold_req_i != 0) m_run = (m_run < 1000) ? m_run + 1 : m_run;
      else m_run = 0;
      if (!m_redir) begin
        if (jump_flag_i) begin m_redir = 1; m_addr = jump_addr_i; end
      end else if (d == 0) m_redir = 0;
    end
  endtask

  function automatic exp_t expect_now();
    exp_t e;
    int d;
    e = '0;
    if (rst_n) begin
      d       = depth_of(hold_req_i, hold_depth_i);
      e.flush = (m_redir || jump_flag_i) ? 5'b00110 : 5'b00000;
      e.hold  = 5'((1 << d) - 1) & ~e.flush;
      e.jf    = m_redir;
      e.addr  = m_addr;
      e.wdog  = (m_run >= 15);
      e.cnt   = 4'(m_cnt);
    end
    return e;
  endfunction

  task automatic cycle(input logic r, input logic jf, input logic [31:0] a,
                       input logic [2:0] rq, input logic [8:0] dp, input logic clr);
    @(posedge clk);
    #1;
    model_edge();
    rst_n = r; jump_flag_i = jf; jump_addr_i = a;
    hold_req_i = rq; hold_depth_i = dp; cnt_clr_i = clr;
    #1;
    sb.push_back(expect_now());
  endtask

  // Monitor: compares DUT against queued expectations on the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cmp("sb_jump_flag", 32'(jump_flag_o), 32'(e.jf));
        cmp("sb_jump_addr", jump_addr_o, e.addr);
        cmp("sb_hold", 32'(hold_o), 32'(e.hold));
        cmp("sb_flush", 32'(flush_o), 32'(e.flush));
        cmp("sb_wdog", 32'(wdog_o), 32'(e.wdog));
        cmp("sb_stall_cnt", 32'(stall_cnt_o), 32'(e.cnt));
      end
    end
  end

  initial begin
    // Reset with all requesters active: outputs must stay 0
    repeat (3) cycle(0, 1, 32'h1234_5678, 3'b111, 9'h1FF, 0);
    cmp("rst_hold", 32'(hold_o), 32'h0);
    cmp("rst_flush", 32'(flush_o), 32'h0);
    cmp("rst_jump_flag", 32'(jump_flag_o), 32'h0);
    repeat (2) cycle(1, 0, 0, 0, 0, 0);

    // Single redirect without holds
    cycle(1, 1, 32'h8000_0100, 0, 0, 0);
    cmp("jmp_T_flush", 32'(flush_o), 32'b00110);
    cmp("jmp_T_flag", 32'(jump_flag_o), 32'h0);
    cycle(1, 0, 0, 0, 0, 0);
    cmp("jmp_T1_flush", 32'(flush_o), 32'b00110);
    cmp("jmp_T1_flag", 32'(jump_flag_o), 32'h1);
    cmp("jmp_T1_addr", jump_addr_o, 32'h8000_0100);
    cycle(1, 0, 0, 0, 0, 0);
    cmp("jmp_T2_flag", 32'(jump_flag_o), 32'h0);
    cmp("jmp_T2_flush", 32'(flush_o), 32'h0);

    // Layered holds and depth clamp
    cycle(1, 0, 0, 3'b101, {3'd3, 3'd0, 3'd1}, 0);
    cmp("layer_both", 32'(hold_o), 32'b00111);
    cycle(1, 0, 0, 3'b001, {3'd3, 3'd0, 3'd1}, 0);
    cmp("layer_req0", 32'(hold_o), 32'b00001);
    cycle(1, 0, 0, 3'b001, {3'd0, 3'd0, 3'd7}, 0);
    cmp("layer_clamp", 32'(hold_o), 32'b11111);

    // Redirect while pc_reg is held by the bus for four cycles
    cycle(1, 1, 32'hCAFE_0040, 3'b010, {3'd0, 3'd1, 3'd0}, 0);
    cmp("bus_T_hold", 32'(hold_o), 32'b00001);
    cmp("bus_T_flush", 32'(flush_o), 32'b00110);
    for (int i = 1; i <= 3; i++) begin
      cycle(1, 0, 0, 3'b010, {3'd0, 3'd1, 3'd0}, 0);
      cmp("bus_held_flag", 32'(jump_flag_o), 32'h1);
      cmp("bus_held_hold", 32'(hold_o), 32'b00001);
    end
    cycle(1, 0, 0, 0, 0, 0);
    cmp("bus_T4_flag", 32'(jump_flag_o), 32'h1);
    cmp("bus_T4_flush", 32'(flush_o), 32'b00110);
    cycle(1, 0, 0, 0, 0, 0);
    cmp("bus_T5_flag", 32'(jump_flag_o), 32'h0);

    // Watchdog and stall counter saturation
    cycle(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      cycle(1, 0, 0, 3'b001, {3'd0, 3'd0, 3'd1}, 0);
      if (i == 14) cmp("wdog_T14", 32'(wdog_o), 32'h0);
      if (i == 15) cmp("wdog_T15", 32'(wdog_o), 32'h1);
    end
    cmp("stall_sat", 32'(stall_cnt_o), 32'd15);
    cycle(1, 0, 0, 0, 0, 0);
    cmp("wdog_hold_over", 32'(wdog_o), 32'h1);
    cycle(1, 0, 0, 3'b001, {3'd0, 3'd0, 3'd1}, 1);
    cmp("wdog_clear", 32'(wdog_o), 32'h0);
    cycle(1, 0, 0, 0, 0, 0);
    cmp("stall_clr", 32'(stall_cnt_o), 32'h0);

    // Reset during a held redirect
    cycle(1, 1, 32'h0000_ABCD, 3'b010, {3'd0, 3'd1, 3'd0}, 0);
    cycle(0, 0, 0, 3'b010, {3'd0, 3'd1, 3'd0}, 0);
    cmp("midrst_flag", 32'(jump_flag_o), 32'h0);
    cmp("midrst_hold", 32'(hold_o), 32'h0);
    cycle(1, 0, 0, 0, 0, 0);
    cmp("postrst_flag", 32'(jump_flag_o), 32'h0);
    cmp("postrst_addr", jump_addr_o, 32'h0);
    cmp("postrst_cnt", 32'(stall_cnt_o), 32'h0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic r, jf, clr;
      logic [2:0] rq;
      r   = ($urandom_range(63) != 0);
      jf  = ($urandom_range(4) == 0);
      rq  = ($urandom_range(2) != 0) ? 3'($urandom) : 3'b000;
      clr = ($urandom_range(31) == 0);
      cycle(r, jf, $urandom, rq, 9'($urandom), clr);
    end

    cycle(1, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got=%0d exp=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline control unit for the RISC-V core. It merges an EX-stage branch/jump redirect with any number of hold requesters (EX multi-cycle ops, CLINT, RIB bus wait) into per-stage hold and flush vectors. It runs a registered redirect handshake to pc_reg, watches for stuck holds, and counts stall cycles. It sits between ex/clint/rib and pc_reg plus the inter-stage registers (if_id, id_ex, ...).

## Interface
- STAGES, 5, number of pipeline registers controlled; index 0 = pc_reg, k = register feeding stage k
- EX_STAGE, 2, highest register index flushed on a redirect (1..EX_STAGE are flushed)
- NREQ, 3, number of hold requesters
- SW, 3, width of each per-requester depth field
- ADDR_W, 32, jump address width
- WDOG_W, 8, hold watchdog counter width
- CNT_W, 32, stall counter width

- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- jump_flag_i  in  1  redirect request from ex, single-cycle pulse
- jump_addr_i  in  ADDR_W  redirect target, valid with jump_flag_i
- hold_req_i  in  NREQ  level hold request per requester
- hold_depth_i  in  NREQ*SW  per-requester freeze depth; field r = bits [r*SW +: SW]
- cnt_clr_i  in  1  synchronous clear of stall_cnt_o
- jump_flag_o  out  1  redirect valid to pc_reg
- jump_addr_o  out  ADDR_W  redirect target to pc_reg
- hold_o  out  STAGES  per-register hold (1 = keep contents)
- flush_o  out  STAGES  per-register flush (1 = load bubble); bit 0 always 0
- wdog_o  out  1  hold-timeout flag
- stall_cnt_o  out  CNT_W  saturating count of cycles with hold_o[0]=1

## Operation
- Reset: rst_n sampled low at a clk edge clears all state. While rst_n is low, all outputs are 0: jump_flag_o, jump_addr_o, hold_o, flush_o, wdog_o, stall_cnt_o.
- Hold depth: D = max of clamp(hold_depth_i[r], STAGES) over r with hold_req_i[r]=1, else 0. Raw hold: hold_raw[k] = (k < D). A field value of 0 requests nothing.
- Redirect FSM, states IDLE and REDIRECT:
  - IDLE: jump_flag_i=1 captures jump_addr_i into jump_addr_o and goes to REDIRECT. In the same cycle, flush_o[EX_STAGE:1]=1.
  - REDIRECT: jump_flag_o=1 and flush_o[EX_STAGE:1]=1. Leave to IDLE at the first edge where hold_raw[0]=0 (pc_reg accepted). Otherwise stay, with jump_flag_o and jump_addr_o stable.
  - jump_flag_i in REDIRECT is ignored; it can only come from a flushed bubble.
- Merge: hold_o[k] = hold_raw[k] & ~flush_o[k]. Flush wins per stage. hold_o[0] = hold_raw[0], including in REDIRECT, so pc_reg load is deferred.
- Watchdog:
  - Counter clears whenever hold_req_i == 0. Otherwise it increments, saturating at 2^WDOG_W-1.
  - wdog_o sets when the counter reaches the max and stays set until hold_req_i == 0 at a clock edge.
- Stall counter:
  - Increments at each edge where hold_o[0]=1, saturating at all-ones.
  - cnt_clr_i has priority over increment.

## Timing
- hold_o and flush_o are combinational from hold_req_i, hold_depth_i, jump_flag_i and the FSM state. There is no added latency for holds.
- Redirect: jump_flag_i at cycle T gives flush at T, jump_flag_o at T+1 and flush at T+1. With no hold, the FSM returns to IDLE at the T+1→T+2 edge, so jump_flag_o is exactly 1 cycle wide.
- If hold_raw[0]=1 at T+1, jump_flag_o and the flushes stay high through every held cycle. They drop one cycle after the first unheld cycle.
- Watchdog: a continuous request starting at cycle T raises wdog_o at T + 2^WDOG_W - 1 (registered). It drops one cycle after requests fall.
- Reset mid-REDIRECT: the pending redirect is discarded. jump_flag_o reads 0 the cycle after the reset edge.
- Simultaneous jump_flag_i and hold in IDLE: flush_o[EX_STAGE:1] is set, hold_o applies to the remaining stages, and the jump is still captured.

## Test plan
- Single redirect, no holds, defaults: jump_flag_i=1 with addr 0x8000_0100 at T.
  - Required: flush_o=5'b00110 at T and T+1; jump_flag_o=1 and jump_addr_o=0x8000_0100 only at T+1.
- Layered holds: req0 depth 1 and req2 depth 3 together.
  - Required: hold_o=5'b00111. Dropping req2 gives 5'b00001. Depth 7 clamps to 5'b11111.
- Redirect during bus hold: req1 depth 1 held for cycles T..T+3, jump at T.
  - Required: jump_flag_o=1 for T+1..T+4, hold_o[0]=1 for T..T+3, hold_o[2:1]=0 and flush_o[2:1]=1 while in REDIRECT, jump_flag_o=0 at T+5.
- Watchdog with WDOG_W=4: req0 held 20 cycles from T.
  - Required: wdog_o rises at T+15, stays high, and clears one cycle after the request drops.
- Stall counter: CNT_W=4, hold_o[0] high 20 cycles.
  - Required: count saturates at 15. cnt_clr_i together with a hold gives 0.
- Reset mid-REDIRECT: rst_n=0 one cycle at T+1 of a held redirect.
  - Required: all outputs are 0 the next cycle and the FSM is in IDLE.
